vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FB_WORDS, default 153600, sets framebuffer size in words (640x480 pixels at 2 pixels per word).
REQ-002 Parameter FIFO_DEPTH, default 8, sets pixel prefetch FIFO depth in pixels; the value SHALL be even and at least 4.
REQ-003 Parameter HOST_MAX_WAIT, default 16, sets host starvation limit in cycles.
REQ-004 The interface SHALL provide exactly these ports:
- clk_50Mhz  in  1  sole clock; one clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_frame_start  in  1  pulse; restart display scan at word 0.
- i_pix_pop  in  1  display consumes the head pixel.
- o_pix_r / o_pix_g / o_pix_b  out  1 each  head pixel colour.
- o_pix_valid  out  1  FIFO not empty.
- o_underrun  out  1  sticky flag, set on a pop while the FIFO is empty.
- i_host_req  in  1  host access request.
- i_host_we  in  1  1 = write, 0 = read.
- i_host_addr  in  18  host word address.
- i_host_wdata  in  8  host write data.
- o_host_gnt  out  1  one-cycle grant pulse.
- o_host_rdata  out  8  host read data.
- o_host_rvalid  out  1  host read data valid.
- o_mem_en  out  1  SRAM access enable.
- o_mem_we  out  1  SRAM write enable.
- o_mem_addr  out  18  SRAM word address.
- o_mem_wdata  out  8  SRAM write data.
- i_mem_rdata  in  8  SRAM read data, valid exactly 1 cycle after a read.

Function
REQ-005 Word format SHALL be: bits [2:0] = even pixel {r,g,b}, bits [6:4] = odd pixel {r,g,b}, bits 3 and 7 unused; the even pixel enters the FIFO first.
REQ-006 At most one SRAM access SHALL be issued per cycle; o_mem_* SHALL be driven combinationally from the arbitration decision of that cycle.
REQ-007 Display need SHALL be true when (FIFO occupancy + pixels in flight) <= FIFO_DEPTH-2.
REQ-008 Arbitration SHALL be decided per cycle:
- If the host has waited HOST_MAX_WAIT cycles and occupancy >= 4, the host wins.
- Otherwise a display need wins.
- Otherwise a pending host request wins.
- Otherwise the SRAM is idle.
REQ-009 The host wait counter SHALL count cycles in which i_host_req=1 and no grant is issued; it SHALL clear on a grant or when the request drops, and SHALL saturate at HOST_MAX_WAIT.
REQ-010 A display fetch SHALL read at the display address counter, then increment the counter; the counter SHALL wrap from FB_WORDS-1 to 0.
REQ-011 When a display read returns, both pixels SHALL be pushed into the FIFO in the same cycle.
REQ-012 A host grant SHALL assert o_host_gnt for the access cycle, with o_mem_addr=i_host_addr and o_mem_we=i_host_we.
REQ-013 The host SHALL hold req, we, addr and wdata stable until it sees gnt; back-to-back grants SHALL be allowed.
REQ-014 For a host read, o_host_rvalid=1 and o_host_rdata=i_mem_rdata SHALL be presented exactly 1 cycle after the grant.
REQ-015 A one-bit return tag SHALL steer each read return to either the FIFO or the host.
REQ-016 The FIFO SHALL be show-ahead: o_pix_r/g/b reflect the head entry and o_pix_valid = not empty.
REQ-017 A pop on a non-empty FIFO SHALL remove one pixel.
REQ-018 A pop on an empty FIFO SHALL leave the FIFO unchanged, set o_underrun, and read o_pix_r/g/b as 0.
REQ-019 A push and a pop in the same cycle SHALL net occupancy +1 (2 in, 1 out).
REQ-020 i_frame_start SHALL, in the next cycle:
- empty the FIFO;
- set the display address to 0;
- discard any display read return for an access issued before the pulse.
Host transactions SHALL be unaffected.
REQ-021 i_frame_start SHALL take precedence over a simultaneous pop or push.
REQ-022 No FIFO overflow SHALL be possible; this is guaranteed by REQ-007.

Reset
REQ-023 While reset=1 the block SHALL hold: FIFO empty, display address 0, wait counter 0, tags cleared, and outputs o_pix_valid, o_underrun, o_host_gnt, o_host_rvalid, o_mem_en, o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0, o_host_rdata = 0.
REQ-024 A read return arriving in the cycle after reset deasserts SHALL be discarded, even if its access was issued before reset.

Verification
REQ-025 The bench SHALL cover these scenarios:
- Scenario 1: release reset, no host, no pops, SRAM word n = n[7:0]. Expect reads at addresses 0,1,2,3 on consecutive cycles, fetching stopping with occupancy 8, head pixel = 3'b000.
- Scenario 2: pop every cycle from a full FIFO with SRAM data 8'h75. Expect pixels alternating 101, 111, o_underrun never set, steady refetch.
- Scenario 3: host read of address 18'h00100 (data 8'hA5) while the FIFO is full. Expect gnt in the first cycle and rvalid with 8'hA5 the next cycle.
- Scenario 4: host write request held while display pops continuously. Expect gnt within 17 cycles, and only when occupancy >= 4.
- Scenario 5: i_frame_start with a display read in flight. Expect the returned data dropped, FIFO empty, next fetch at address 0.
- Scenario 6: display address at FB_WORDS-1. Expect the next fetch at 0. Then pop with the FIFO empty: expect o_underrun=1 sticky and pixel 000.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer SRAM between a display prefetch FIFO and a host port.
// Display fetches take priority, but a host that has waited long enough wins once the FIFO can cover the gap.
module vga_fb_arbiter #(
  parameter int FB_WORDS      = 153600,
  parameter int FIFO_DEPTH    = 8,
  parameter int HOST_MAX_WAIT = 16
) (
  input  logic        clk_50Mhz,
  input  logic        reset,
  input  logic        i_frame_start,
  input  logic        i_pix_pop,
  output logic        o_pix_r,
  output logic        o_pix_g,
  output logic        o_pix_b,
  output logic        o_pix_valid,
  output logic        o_underrun,
  input  logic        i_host_req,
  input  logic        i_host_we,
  input  logic [17:0] i_host_addr,
  input  logic [7:0]  i_host_wdata,
  output logic        o_host_gnt,
  output logic [7:0]  o_host_rdata,
  output logic        o_host_rvalid,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [17:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(HOST_MAX_WAIT + 1);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_odd;
  logic [CW-1:0] count_reg, count_next;
  logic [17:0]   disp_addr_reg, disp_addr_next;
  logic [WW-1:0] wait_reg, wait_next;
  logic          disp_tag_reg, disp_tag_next;
  logic          host_tag_reg, host_tag_next;
  logic          underrun_reg, underrun_next;

  logic [3*FIFO_DEPTH-1:0] fifo_flat;
  logic [2:0]    head_pix;
  logic          fifo_empty;
  logic          push;
  logic          pop_ok;
  logic          pop_empty;
  logic          disp_need;
  logic          host_starved;
  logic          disp_win;
  logic          host_win;
  logic          unused_rdata_bits;

  assign unused_rdata_bits = i_mem_rdata[7] ^ i_mem_rdata[3];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ptr_odd = ptr_inc(wr_ptr_reg);

  // Each FIFO slot is its own register; a returning word writes two adjacent slots.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      logic [2:0] entry_reg;
      always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= i_mem_rdata[2:0];
        end else if (push && (wr_ptr_odd == PW'(gi))) begin
          entry_reg <= i_mem_rdata[6:4];
        end
      end
      assign fifo_flat[3*gi +: 3] = entry_reg;
    end
  endgenerate

  assign head_pix = fifo_flat[32'(rd_ptr_reg) * 3 +: 3];

  // Arbitration: a frame restart suppresses display fetches so nothing stale is issued.
  always_comb begin
    fifo_empty   = (count_reg == '0);
    push         = disp_tag_reg && !i_frame_start;
    pop_ok       = i_pix_pop && !fifo_empty && !i_frame_start;
    pop_empty    = i_pix_pop && fifo_empty && !i_frame_start;
    disp_need    = !i_frame_start &&
                   ((32'(count_reg) + (disp_tag_reg ? 32'd2 : 32'd0)) <= 32'(FIFO_DEPTH - 2));
    host_starved = i_host_req && (wait_reg == WW'(HOST_MAX_WAIT)) && (32'(count_reg) >= 32'd4);
    disp_win     = !reset && disp_need && !host_starved;
    host_win     = !reset && i_host_req && !disp_win;
  end

  always_comb begin
    o_mem_en      = disp_win || host_win;
    o_mem_we      = host_win && i_host_we;
    o_mem_addr    = disp_win ? disp_addr_reg : (host_win ? i_host_addr : '0);
    o_mem_wdata   = (host_win && i_host_we) ? i_host_wdata : '0;
    o_host_gnt    = host_win;
    o_host_rvalid = host_tag_reg && !reset;
    o_host_rdata  = (host_tag_reg && !reset) ? i_mem_rdata : '0;
    o_pix_valid   = !fifo_empty && !reset;
    {o_pix_r, o_pix_g, o_pix_b} = (fifo_empty || reset) ? 3'b000 : head_pix;
    o_underrun    = underrun_reg && !reset;
  end

  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    disp_addr_next = disp_addr_reg;
    underrun_next  = underrun_reg || pop_empty;
    wait_next      = wait_reg;
    if (i_frame_start) begin
      rd_ptr_next    = '0;
      wr_ptr_next    = '0;
      count_next     = '0;
      disp_addr_next = '0;
    end else begin
      if (pop_ok) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (push) begin
        wr_ptr_next = ptr_inc(wr_ptr_odd);
      end
      count_next = count_reg + (push ? CW'(2) : CW'(0)) - (pop_ok ? CW'(1) : CW'(0));
      if (disp_win) begin
        disp_addr_next = (disp_addr_reg == 18'(FB_WORDS - 1)) ? '0 : disp_addr_reg + 18'd1;
      end
    end
    // Tags follow each access by one cycle to steer the SRAM return.
    disp_tag_next = disp_win;
    host_tag_next = host_win && !i_host_we;
    if (!i_host_req || host_win) begin
      wait_next = '0;
    end else if (wait_reg != WW'(HOST_MAX_WAIT)) begin
      wait_next = wait_reg + WW'(1);
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      disp_addr_reg <= '0;
      wait_reg      <= '0;
      disp_tag_reg  <= 1'b0;
      host_tag_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      disp_addr_reg <= disp_addr_next;
      wait_reg      <= wait_next;
      disp_tag_reg  <= disp_tag_next;
      host_tag_reg  <= host_tag_next;
      underrun_reg  <= underrun_next;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus a random phase, checked every cycle
// against a queue-based model of the FIFO, arbitration rules and SRAM contents.
module tb_vga_fb_arbiter;
  localparam int FB    = 24;
  localparam int DEPTH = 8;
  localparam int MAXW  = 16;

  logic        clk_50Mhz = 1'b0;
  logic        reset = 1'b1;
  logic        i_frame_start = 1'b0;
  logic        i_pix_pop = 1'b0;
  logic        o_pix_r, o_pix_g, o_pix_b, o_pix_valid, o_underrun;
  logic        i_host_req = 1'b0;
  logic        i_host_we = 1'b0;
  logic [17:0] i_host_addr = '0;
  logic [7:0]  i_host_wdata = '0;
  logic        o_host_gnt, o_host_rvalid;
  logic [7:0]  o_host_rdata;
  logic        o_mem_en, o_mem_we;
  logic [17:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  mem_rdata = '0;

  vga_fb_arbiter #(.FB_WORDS(FB), .FIFO_DEPTH(DEPTH), .HOST_MAX_WAIT(MAXW)) dut (
    .clk_50Mhz(clk_50Mhz), .reset(reset), .i_frame_start(i_frame_start), .i_pix_pop(i_pix_pop),
    .o_pix_r(o_pix_r), .o_pix_g(o_pix_g), .o_pix_b(o_pix_b), .o_pix_valid(o_pix_valid),
    .o_underrun(o_underrun), .i_host_req(i_host_req), .i_host_we(i_host_we),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt),
    .o_host_rdata(o_host_rdata), .o_host_rvalid(o_host_rvalid), .o_mem_en(o_mem_en),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk_50Mhz = ~clk_50Mhz;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM environment: one-cycle read latency, driven by the DUT's memory port.
  logic [7:0] sram [0:262143];
  always @(posedge clk_50Mhz) begin
    if (o_mem_en) begin
      if (o_mem_we) sram[o_mem_addr] = o_mem_wdata;
      else mem_rdata <= sram[o_mem_addr];
    end
  end

  // Model state: pixel queue, pending read, display address, host wait, own memory copy.
  bit [2:0]  m_q[$];
  bit        m_under = 0;
  int        m_addr = 0;
  int        m_wait = 0;
  bit        m_pend_disp = 0;
  bit        m_pend_host = 0;
  bit [7:0]  m_pend_data = 0;
  bit [7:0]  model_mem [0:262143];

  bit        d_reset = 1, d_fs = 0, d_pop = 0, d_disp = 0, d_host = 0, d_we = 0, d_req = 0;
  bit [17:0] d_haddr = 0;
  bit [7:0]  d_hwdata = 0;
  bit        gnt_seen = 0;

  always @(negedge clk_50Mhz) begin : cmp
    bit starved, need, dw, hw, ev, er;
    bit [2:0] ep;
    dw = 0; hw = 0;
    if (!reset) begin
      starved = i_host_req && (m_wait == MAXW) && (m_q.size() >= 4);
      need    = !i_frame_start && ((m_q.size() + (m_pend_disp ? 2 : 0)) <= DEPTH - 2);
      dw      = need && !starved;
      hw      = i_host_req && !dw;
    end
    ev = !reset && (m_q.size() > 0);
    ep = ev ? m_q[0] : 3'b000;
    er = !reset && m_pend_host;
    chk("pix_valid", o_pix_valid, ev);
    chk("pix_rgb", {o_pix_r, o_pix_g, o_pix_b}, ep);
    chk("underrun", o_underrun, !reset && m_under);
    chk("mem_en", o_mem_en, dw || hw);
    chk("host_gnt", o_host_gnt, hw);
    chk("mem_we", o_mem_we, hw && i_host_we);
    chk("host_rvalid", o_host_rvalid, er);
    if (er) chk("host_rdata", o_host_rdata, m_pend_data);
    if (dw) chk("disp_addr", o_mem_addr, m_addr);
    if (hw) chk("host_addr", o_mem_addr, i_host_addr);
    if (hw && i_host_we) chk("host_wdata", o_mem_wdata, i_host_wdata);
    if (reset) begin
      chk("rst_addr", o_mem_addr, 0);
      chk("rst_wdata", o_mem_wdata, 0);
      chk("rst_rdata", o_host_rdata, 0);
    end
    d_reset = reset; d_fs = i_frame_start; d_pop = i_pix_pop; d_disp = dw; d_host = hw;
    d_we = i_host_we; d_req = i_host_req; d_haddr = i_host_addr; d_hwdata = i_host_wdata;
    gnt_seen = o_host_gnt;
  end

  always @(posedge clk_50Mhz) begin : mdl
    bit pd;
    bit [7:0] pdata;
    if (d_reset) begin
      m_q.delete(); m_under = 0; m_addr = 0; m_wait = 0; m_pend_disp = 0; m_pend_host = 0;
    end else begin
      pd = m_pend_disp; pdata = m_pend_data;
      if (d_fs) begin
        m_q.delete(); m_addr = 0;
      end else begin
        if (d_pop) begin
          if (m_q.size() > 0) void'(m_q.pop_front());
          else m_under = 1;
        end
        if (pd) begin m_q.push_back(pdata[2:0]); m_q.push_back(pdata[6:4]); end
      end
      m_pend_disp = d_disp;
      m_pend_host = d_host && !d_we;
      if (d_disp) begin
        m_pend_data = model_mem[m_addr];
        m_addr = (m_addr == FB - 1) ? 0 : m_addr + 1;
      end else if (d_host) begin
        if (d_we) model_mem[d_haddr] = d_hwdata;
        else m_pend_data = model_mem[d_haddr];
      end
      m_wait = (!d_req || d_host) ? 0 : ((m_wait < MAXW) ? m_wait + 1 : MAXW);
    end
  end

  // Stimulus driver: host holds its request until it sees a grant.
  int        pop_mode = 0;
  bit        fs_req = 0;
  bit        hq_we[$];
  bit [17:0] hq_addr[$];
  bit [7:0]  hq_data[$];

  task automatic cycle();
    @(posedge clk_50Mhz); #1;
    if (i_host_req && gnt_seen) i_host_req = 0;
    if (!i_host_req && hq_we.size() > 0) begin
      i_host_we = hq_we.pop_front();
      i_host_addr = hq_addr.pop_front();
      i_host_wdata = hq_data.pop_front();
      i_host_req = 1;
    end
    i_frame_start = fs_req;
    fs_req = 0;
    i_pix_pop = i_frame_start ? 1'b0 :
                (pop_mode == 1) ? 1'b1 : (pop_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic host_op(input bit we, input bit [17:0] a, input bit [7:0] d);
    hq_we.push_back(we); hq_addr.push_back(a); hq_data.push_back(d);
  endtask

  task automatic set_word(input int a, input bit [7:0] d);
    sram[a] = d; model_mem[a] = d;
  endtask

  initial begin
    int fetches;
    bit found;
    for (int n = 0; n < 262144; n++) set_word(n, 8'(n));
    repeat (3) cycle();
    @(negedge clk_50Mhz);
    chk("reset_pix_valid", o_pix_valid, 0);
    chk("reset_mem_en", o_mem_en, 0);

    // Scenario 1: fill from reset
    cycle(); reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_50Mhz);
      chk("s1_fetch_en", o_mem_en, 1);
      chk("s1_fetch_addr", o_mem_addr, k);
      cycle();
    end
    repeat (3) cycle();
    @(negedge clk_50Mhz);
    chk("s1_idle", o_mem_en, 0);
    chk("s1_valid", o_pix_valid, 1);
    chk("s1_head", {o_pix_r, o_pix_g, o_pix_b}, 3'b000);
    chk("s1_model_occ", m_q.size(), 8);

    // Scenario 2: continuous pop of 8'h75 words
    for (int n = 0; n < FB; n++) set_word(n, 8'h75);
    fs_req = 1; cycle();
    repeat (10) cycle();
    pop_mode = 1; fetches = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      @(negedge clk_50Mhz);
      chk("s2_pix", {o_pix_r, o_pix_g, o_pix_b}, (k % 2 == 0) ? 3'b101 : 3'b111);
      if (o_mem_en) fetches++;
    end
    pop_mode = 0;
    chk("s2_underrun", o_underrun, 0);
    chk("s2_refetch", fetches >= 12, 1);

    // Scenario 3: host read while FIFO full
    repeat (10) cycle();
    set_word(18'h00100, 8'hA5);
    host_op(0, 18'h00100, 8'h00);
    cycle();
    @(negedge clk_50Mhz);
    chk("s3_gnt", o_host_gnt, 1);
    chk("s3_addr", o_mem_addr, 18'h00100);
    chk("s3_we", o_mem_we, 0);
    cycle();
    @(negedge clk_50Mhz);
    chk("s3_rvalid", o_host_rvalid, 1);
    chk("s3_rdata", o_host_rdata, 8'hA5);

    // Scenario 4: host write under continuous display pops
    host_op(1, 18'h00200, 8'h3C);
    pop_mode = 1;
    cycle();
    found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk_50Mhz);
      if (o_host_gnt) begin
        found = 1;
        chk("s4_gnt_latency", k <= 17, 1);
        chk("s4_gnt_occ", m_q.size() >= 4, 1);
      end
      cycle();
    end
    chk("s4_granted", found, 1);
    pop_mode = 0;
    repeat (10) cycle();
    host_op(0, 18'h00200, 8'h00);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      @(negedge clk_50Mhz);
      if (o_host_gnt) found = 1;
    end
    cycle();
    @(negedge clk_50Mhz);
    chk("s4_readback", {found, o_host_rvalid, o_host_rdata}, {1'b1, 1'b1, 8'h3C});

    // Scenario 5: frame start with a display read in flight
    pop_mode = 1; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      @(negedge clk_50Mhz);
      if (o_mem_en && !o_host_gnt) found = 1;
    end
    chk("s5_found_fetch", found, 1);
    pop_mode = 0; fs_req = 1;
    cycle();
    cycle();
    @(negedge clk_50Mhz);
    chk("s5_empty", o_pix_valid, 0);
    chk("s5_fetch_en", o_mem_en, 1);
    chk("s5_fetch_addr0", o_mem_addr, 0);
    cycle();
    @(negedge clk_50Mhz);
    chk("s5_dropped", o_pix_valid, 0);
    cycle();
    @(negedge clk_50Mhz);
    chk("s5_refill", o_pix_valid, 1);
    chk("s5_refill_pix", {o_pix_r, o_pix_g, o_pix_b}, 3'b101);

    // Scenario 6: address wrap, then underrun
    repeat (10) cycle();
    pop_mode = 1; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      @(negedge clk_50Mhz);
      if (o_mem_en && !o_host_gnt && o_mem_addr == 18'(FB - 1)) found = 1;
    end
    chk("s6_found_last", found, 1);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      @(negedge clk_50Mhz);
      if (o_mem_en && !o_host_gnt) begin
        found = 1;
        chk("s6_wrap_addr", o_mem_addr, 0);
      end
    end
    chk("s6_found_wrap", found, 1);
    chk("s6_no_underrun_yet", o_underrun, 0);
    pop_mode = 0; fs_req = 1;
    cycle();
    pop_mode = 1;
    cycle();
    @(negedge clk_50Mhz);
    chk("s6_empty_pix", {o_pix_valid, o_pix_r, o_pix_g, o_pix_b}, 4'b0000);
    pop_mode = 0;
    cycle();
    @(negedge clk_50Mhz);
    chk("s6_underrun_set", o_underrun, 1);
    repeat (6) cycle();
    @(negedge clk_50Mhz);
    chk("s6_underrun_sticky", {o_underrun, o_pix_valid}, 2'b11);

    // Random phase with frame restarts, host traffic and a mid-run reset
    pop_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) fs_req = 1;
      if (hq_we.size() < 2 && $urandom_range(0, 7) == 0)
        host_op(1'($urandom_range(0, 1)), 18'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
      cycle();
      if (i == 1500) reset = 1;
      if (i == 1503) reset = 0;
    end
    pop_mode = 0;
    repeat (40) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
